stage_ex_alu: RTL
=================

# stage_ex_alu

Execute-stage ALU of the pipelined processor, sitting directly downstream of the ID/EX stage register. It consumes the ID/EX outputs, RD1, RD2, num, ALUSrc and ALUOp, and produces the ALU result and zero flag for the EX/MEM register. Single-cycle operations are combinational. Multiply and divide run on an iterative 32-step unit that raises a stall to freeze the upstream pipeline until the result is ready.

## Interface
- No parameters; data width fixed at 32, iteration count fixed at 32.
- clk  input  1  pipeline clock; all state updates on the falling edge, matching the stage registers.
- rst  input  1  reset, asynchronous, active-low.
- ALUOp_in  input  3  operation select from ID/EX.
- ALUSrc_in  input  1  1: operand B = num_in; 0: operand B = RD2_in.
- RD1_in  input  32  operand A.
- RD2_in  input  32  register operand B.
- num_in  input  32  immediate operand B.
- flush_in  input  1  active-high abort of any in-flight multi-cycle operation.
- alu_result_out  output  32  result to EX/MEM.
- zero_out  output  1  1 when alu_result_out == 0.
- stall_out  output  1  hold ID/EX and all upstream stages while high.

## Operation
- Operand B is num_in when ALUSrc_in = 1, otherwise RD2_in.
- ALUOp encoding:
  - 000 add, 001 sub, 010 and, 011 or.
  - 100 logical shift left by B[4:0]; 101 logical shift right by B[4:0].
  - 110 multiply, returning the low 32 bits of the product.
  - 111 unsigned divide, returning the quotient.
- Add and sub wrap modulo 2^32 with no overflow flag.
- Ops 000–101 are combinational in every state except DONE. alu_result_out follows the inputs in the same cycle.
- The multi-cycle FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - If ALUOp_in is 110/111 and flush_in = 0, stall_out = 1 combinationally.
  - The next falling edge latches A and B, clears the iteration counter, and moves to BUSY.
  - Otherwise the FSM stays in IDLE.
- BUSY:
  - stall_out = 1.
  - Each falling edge performs one step: shift-add for multiply, restoring shift-subtract for divide. The counter then increments.
  - After the 32nd step the FSM moves to DONE and the result register holds the final value.
- DONE:
  - stall_out = 0; alu_result_out is the result register.
  - The next falling edge moves to IDLE. That same edge lets ID/EX load the next instruction and EX/MEM capture the result.
  - A following mul/div then starts normally from IDLE.
- Divide by zero: the quotient is 0xFFFFFFFF. The divide still takes the full 32 steps.
- zero_out is always the reduction-NOR of alu_result_out.
- flush_in = 1:
  - stall_out is forced to 0.
  - In BUSY or DONE, the next falling edge returns the FSM to IDLE and discards the result.
  - In IDLE, no start occurs.
- During reset (rst = 0):
  - FSM goes to IDLE, counter and result register clear to 0.
  - Outputs are forced: alu_result_out = 0, zero_out = 1, stall_out = 0.
  - Reset takes effect immediately, mid-operation included.

## Timing
- Single-cycle ops have zero-cycle latency (combinational through EX).
- Multiply/divide sequence:
  - stall_out is high for 33 consecutive cycles: 1 IDLE cycle plus 32 BUSY cycles.
  - The result is valid in the following DONE cycle.
  - Total EX occupancy is 34 cycles.
- Back-to-back mul/div: the second operation begins its IDLE stall cycle immediately after DONE, with no extra bubble.
- On rst release, the first active falling edge starts from IDLE.
- flush_in has priority over start and over the BUSY/DONE transitions. Asynchronous reset has priority over everything.

## Test plan
- Add with immediate: ALUOp=000, RD1=5, ALUSrc=1, num=7 -> alu_result_out=12, zero_out=0, stall_out=0 in the same cycle.
- Sub to zero, then shift:
  - ALUOp=001, RD1=RD2=9, ALUSrc=0 -> result 0, zero_out=1.
  - Then ALUOp=101, RD1=0x80000000, num=31, ALUSrc=1 -> result 1.
- Multiply: ALUOp=110, RD1=1234, RD2=5678 -> stall_out high for exactly 33 cycles, then result 7006652 (0x006AE9BC) for one DONE cycle, then FSM in IDLE.
- Divide, then divide by zero, back-to-back:
  - 100/7 -> 14 after 33 stall cycles.
  - The next instruction 55/0 -> 0xFFFFFFFF after a further 33 stall cycles, with no idle gap between the two.
- Reset mid-multiply: drop rst after the 10th BUSY step -> outputs immediately 0 / 1 / 0, FSM in IDLE. After release, a new 3×4 multiply returns 12 with full timing.
- Flush: assert flush_in during a BUSY step -> stall_out=0 that cycle, FSM in IDLE at the next edge, no DONE cycle. A subsequent add produces its correct combinational result.

Source files
------------

// File: rtl/stage_ex_alu_if.sv
// Operand/result bundle between the ID/EX register and the EX-stage ALU.
// The ALU drives the result, zero flag and pipeline stall back out.
interface stage_ex_alu_if;
    logic [2:0]  ALUOp_in;
    logic        ALUSrc_in;
    logic [31:0] RD1_in;
    logic [31:0] RD2_in;
    logic [31:0] num_in;
    logic        flush_in;
    logic [31:0] alu_result_out;
    logic        zero_out;
    logic        stall_out;

    modport master (
        output ALUOp_in, ALUSrc_in, RD1_in, RD2_in, num_in, flush_in,
        input  alu_result_out, zero_out, stall_out
    );

    modport slave (
        input  ALUOp_in, ALUSrc_in, RD1_in, RD2_in, num_in, flush_in,
        output alu_result_out, zero_out, stall_out
    );
endinterface

// File: rtl/stage_ex_alu.sv
// EX-stage ALU: combinational add/sub/logic/shift plus an iterative
// 32-step multiply/divide unit that stalls upstream until done.
module stage_ex_alu (
    input logic           clk,
    input logic           rst,
    stage_ex_alu_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] rem_q;
    logic [31:0] res_q;
    logic        div_q;

    logic [31:0] op_b;
    logic [31:0] comb_res;
    logic        is_md;
    logic [31:0] mul_acc;
    logic [32:0] trial;
    logic [32:0] diff;
    logic        ge;
    logic [31:0] rem_n;
    logic [31:0] quo_n;
    logic [31:0] result;

    assign op_b  = bus.ALUSrc_in ? bus.num_in : bus.RD2_in;
    assign is_md = bus.ALUOp_in[2] & bus.ALUOp_in[1];

    always_comb begin
        comb_res = 32'd0;
        unique case (bus.ALUOp_in)
            3'b000:  comb_res = bus.RD1_in + op_b;
            3'b001:  comb_res = bus.RD1_in - op_b;
            3'b010:  comb_res = bus.RD1_in & op_b;
            3'b011:  comb_res = bus.RD1_in | op_b;
            3'b100:  comb_res = bus.RD1_in << op_b[4:0];
            3'b101:  comb_res = bus.RD1_in >> op_b[4:0];
            3'b110:  comb_res = 32'd0;
            3'b111:  comb_res = 32'd0;
            default: comb_res = 32'd0;
        endcase
    end

    // Multiply: a_q is the left-shifting multiplicand, b_q the right-shifting multiplier.
    assign mul_acc = b_q[0] ? res_q + a_q : res_q;

    // Divide: a_q shifts dividend bits out and quotient bits in; b = 0 yields all ones.
    assign trial = {rem_q, a_q[31]};
    assign diff  = trial - {1'b0, b_q};
    assign ge    = ~diff[32];
    assign rem_n = ge ? diff[31:0] : trial[31:0];
    assign quo_n = {a_q[30:0], ge};

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 5'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            rem_q <= 32'd0;
            res_q <= 32'd0;
            div_q <= 1'b0;
        end else if (bus.flush_in) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (is_md) begin
                        a_q   <= bus.RD1_in;
                        b_q   <= op_b;
                        rem_q <= 32'd0;
                        res_q <= 32'd0;
                        cnt   <= 5'd0;
                        div_q <= bus.ALUOp_in[0];
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (div_q) begin
                        a_q   <= quo_n;
                        rem_q <= rem_n;
                        res_q <= quo_n;
                    end else begin
                        res_q <= mul_acc;
                        a_q   <= a_q << 1;
                        b_q   <= b_q >> 1;
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign result = !rst ? 32'd0 :
                    (state == DONE) ? res_q : comb_res;

    assign bus.alu_result_out = result;
    assign bus.zero_out       = ~|result;
    assign bus.stall_out      = rst && !bus.flush_in &&
                                ((state == BUSY) || (state == IDLE && is_md));

endmodule
